counter_updown_param: RTL and testbench
=======================================

# counter_updown_param

Parametrised up/down counter with a configurable modulus, parallel load, wrap or saturate mode, and registered overflow/underflow pulses with sticky flags. It is the next-generation general counter for the chapter's design set. It replaces fixed 8-bit up-only counters wherever a width, modulus or direction other than 8-bit/256/up is needed. It sits between control logic, which drives the enable, clear and load inputs, and status or timing consumers of the count and flags.

## Interface
- WIDTH, 8: counter width in bits, 2..32.
- MODULO, 2**WIDTH: count range 0..MODULO-1, 2 ≤ MODULO ≤ 2**WIDTH.
- PRESCALE, 4: enabled cycles per count step. Present only with COUNTER_PRESCALE_EN; must be ≥ 1.

- clk  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- EN  in  1  count enable.
- CLR  in  1  clear counter to 0 and clear sticky flags.
- LOAD  in  1  parallel load of load_value.
- load_value  in  WIDTH  value to load.
- UP  in  1  direction: 1 = increment, 0 = decrement.
- SAT  in  1  mode: 1 = saturate at the range ends, 0 = wrap.
- FLAG_CLR  in  1  clear sticky flags only.
- counter  out  WIDTH  current count, registered.
- OV  out  1  one-cycle registered overflow pulse.
- UF  out  1  one-cycle registered underflow pulse.
- OV_STK  out  1  sticky overflow flag.
- UF_STK  out  1  sticky underflow flag.
- TC  out  1  terminal count, combinational from counter and UP: counter == MODULO-1 when UP = 1, counter == 0 when UP = 0.

## Operation
- Reset is synchronous and active-high. In a Reset cycle the next state is counter = 0, OV = UF = 0, OV_STK = UF_STK = 0, prescaler = 0.
- Priority per cycle is Reset > CLR > LOAD > EN. The lower-priority inputs are ignored when a higher one is active.
- **CLR**
  - counter ← 0, OV = UF = 0, both sticky flags ← 0, prescaler ← 0.
- **LOAD**
  - counter ← load_value.
  - If load_value ≥ MODULO, counter ← MODULO-1 (clamped). A clamped load produces no OV pulse.
  - Prescaler ← 0. No OV or UF pulse.
- **EN step, UP = 1**
  - Below MODULO-1: counter ← counter+1.
  - At MODULO-1 with SAT = 0: counter ← 0 and OV pulses.
  - At MODULO-1 with SAT = 1: counter holds and OV pulses on every attempted step.
- **EN step, UP = 0**
  - Above 0: counter ← counter-1.
  - At 0 with SAT = 0: counter ← MODULO-1 and UF pulses.
  - At 0 with SAT = 1: counter holds and UF pulses.
- **Idle** (EN = 0, no LOAD or CLR): counter and prescaler hold; OV = UF = 0.
- **Sticky flags**
  - OV_STK is set in the cycle OV is set; UF_STK likewise follows UF.
  - FLAG_CLR clears both sticky flags.
  - If FLAG_CLR coincides with a new OV or UF event, set wins.
- UP and SAT may change on any cycle. They take effect on the next step with no pipeline hazard.
- **Arithmetic:** all next-count arithmetic is done at WIDTH+1 bits, then compared against MODULO-1. No intermediate value may truncate when MODULO = 2**WIDTH.

## Timing
- Single clock domain; every output except TC is registered.
- Latency is one cycle: inputs sampled at edge N appear on counter/OV/UF after edge N.
- OV/UF are high in the same cycle the wrapped or held count is visible, for exactly one cycle per event.
- With back-to-back events (EN held at the range end in saturate mode), OV/UF stay high on consecutive cycles, one pulse per step.
- Reset mid-count takes effect at the next edge regardless of EN, LOAD or CLR.
- TC has combinational delay only from counter and UP.

## Configuration
- COUNTER_PRESCALE_EN
  - **Defined:** an internal prescaler counts EN-high cycles. The counter steps only on the enabled cycle where the prescaler equals PRESCALE-1, then the prescaler returns to 0. With PRESCALE = 1 the behaviour is identical to the undefined case.
  - **Undefined:** the prescaler logic and the PRESCALE parameter are absent, and every EN-high cycle is a step.

## Structure
- **Shared package counter_pkg:**
  - Direction constants DIR_DOWN = 1'b0 and DIR_UP = 1'b1.
  - Mode constants MODE_WRAP = 1'b0 and MODE_SAT = 1'b1.
  - A function computing the clamped load value from load_value and MODULO.
- **Sub-module counter_prescaler:** ports clk, Reset, clr, en, tick. It is instantiated only under COUNTER_PRESCALE_EN. In counter_prescaler, clr comes from CLR or LOAD.
- The top level holds the count register, the flag registers and the TC decode.

## Test plan
- **Wrap up:** WIDTH = 8, MODULO = 10, UP = 1, SAT = 0, EN held for 12 cycles from 0. The counter runs 1..9, 0, 1, 2. OV is high only in the cycle the counter shows 0, and OV_STK = 1 afterwards.
- **Saturate down:** MODULO = 10, load 2, then UP = 0, SAT = 1, EN for 4 cycles. The counter shows 1, 0, 0, 0, and UF pulses on the 3rd and 4th steps. TC = 1 while the counter = 0.
- **Load clamp and priority:** load_value = 200 with MODULO = 10 gives counter = 9. LOAD and EN together with load_value = 3 give counter = 3. CLR and LOAD together give counter = 0 and clear the sticky flags.
- **Sticky race:** FLAG_CLR asserted in the same cycle as an OV event leaves OV_STK = 1. FLAG_CLR alone on the next cycle clears it to 0.
- **Reset mid-count:** Reset with EN = 1 at counter = 7 gives counter = 0 with all flags 0 on the next edge, and counting resumes one cycle after Reset deasserts.
- **Prescale (COUNTER_PRESCALE_EN, PRESCALE = 4):** EN held for 8 cycles gives counter = 2. A LOAD mid-sequence restarts the 4-cycle step window.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
// Direction/mode encodings and the load-clamp function live here so every user agrees on them.
package counter_pkg;

  localparam logic DIR_DOWN  = 1'b0;
  localparam logic DIR_UP    = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Widest supported counter; helpers work one bit wider so 2**32 never truncates.
  localparam int CNT_MAX_W = 32;

  // Clamp a load value into 0..max_cnt (max_cnt is MODULO-1).
  function automatic logic [CNT_MAX_W:0] clamp_load(
    input logic [CNT_MAX_W:0] value,
    input logic [CNT_MAX_W:0] max_cnt
  );
    logic [CNT_MAX_W:0] result;
    result = value;
    if (value > max_cnt) begin
      result = max_cnt;
    end
    return result;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Prescaler for counter_updown_param: counts enabled cycles and emits a tick
// on the enabled cycle where the count reaches PRESCALE-1, then restarts.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic Reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt_q;
  logic [PW-1:0] cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/counter_updown_param.sv
// Parametrised up/down counter with modulus, clamped parallel load, wrap/saturate
// mode, registered OV/UF pulses and sticky flags. Optional prescaler: COUNTER_PRESCALE_EN.
module counter_updown_param
  import counter_pkg::*;
#(
  parameter int                WIDTH  = 8,
  parameter longint unsigned   MODULO = 64'd1 << WIDTH
`ifdef COUNTER_PRESCALE_EN
  ,
  parameter int                PRESCALE = 4
`endif
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             EN,
  input  logic             CLR,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] load_value,
  input  logic             UP,
  input  logic             SAT,
  input  logic             FLAG_CLR,
  output logic [WIDTH-1:0] counter,
  output logic             OV,
  output logic             UF,
  output logic             OV_STK,
  output logic             UF_STK,
  output logic             TC
);

  // Range end held at WIDTH+1 bits so MODULO = 2**WIDTH stays exact.
  localparam logic [WIDTH:0] MAX_CNT = (WIDTH + 1)'(MODULO - 64'd1);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             ov_q, ov_d;
  logic             uf_q, uf_d;
  logic             ov_stk_q, ov_stk_d;
  logic             uf_stk_q, uf_stk_d;
  logic             step;

  logic [WIDTH:0]   cnt_ext;
  logic [WIDTH:0]   cnt_inc;
  logic [WIDTH:0]   cnt_dec;
  logic [WIDTH-1:0] load_clamped;

`ifdef COUNTER_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .Reset (Reset),
    .clr   (CLR | LOAD),
    .en    (EN),
    .tick  (step)
  );
`else
  assign step = EN;
`endif

  assign cnt_ext      = {1'b0, cnt_q};
  assign cnt_inc      = cnt_ext + 1'b1;
  assign cnt_dec      = cnt_ext - 1'b1;
  assign load_clamped = WIDTH'(clamp_load((CNT_MAX_W + 1)'(load_value),
                                          (CNT_MAX_W + 1)'(MAX_CNT)));

  always_comb begin
    cnt_d    = cnt_q;
    ov_d     = 1'b0;
    uf_d     = 1'b0;
    ov_stk_d = ov_stk_q;
    uf_stk_d = uf_stk_q;

    if (FLAG_CLR) begin
      ov_stk_d = 1'b0;
      uf_stk_d = 1'b0;
    end

    if (CLR) begin
      cnt_d    = '0;
      ov_stk_d = 1'b0;
      uf_stk_d = 1'b0;
    end else if (LOAD) begin
      cnt_d = load_clamped;
    end else if (step) begin
      if (UP == DIR_UP) begin
        if (cnt_ext == MAX_CNT) begin
          cnt_d = (SAT == MODE_SAT) ? cnt_q : '0;
          ov_d  = 1'b1;
        end else begin
          cnt_d = cnt_inc[WIDTH-1:0];
        end
      end else begin
        if (cnt_ext == '0) begin
          cnt_d = (SAT == MODE_SAT) ? cnt_q : MAX_CNT[WIDTH-1:0];
          uf_d  = 1'b1;
        end else begin
          cnt_d = cnt_dec[WIDTH-1:0];
        end
      end
      // A new event beats a coincident FLAG_CLR.
      if (ov_d) ov_stk_d = 1'b1;
      if (uf_d) uf_stk_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt_q    <= '0;
      ov_q     <= 1'b0;
      uf_q     <= 1'b0;
      ov_stk_q <= 1'b0;
      uf_stk_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      ov_q     <= ov_d;
      uf_q     <= uf_d;
      ov_stk_q <= ov_stk_d;
      uf_stk_q <= uf_stk_d;
    end
  end

  assign counter = cnt_q;
  assign OV      = ov_q;
  assign UF      = uf_q;
  assign OV_STK  = ov_stk_q;
  assign UF_STK  = uf_stk_q;
  assign TC      = (UP == DIR_UP) ? (cnt_ext == MAX_CNT) : (cnt_ext == '0);

endmodule

// File: tb/tb_counter_updown_param.sv
// Directed-vector bench for counter_updown_param (WIDTH=8, MODULO=10); covers
// the prescaled build as well when COUNTER_PRESCALE_EN is defined.
module tb_counter_updown_param;

  localparam int WIDTH = 8;
`ifdef COUNTER_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  logic             clk = 1'b0;
  logic             Reset, EN, CLR, LOAD, UP, SAT, FLAG_CLR;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] counter;
  logic             OV, UF, OV_STK, UF_STK, TC;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  counter_updown_param #(
    .WIDTH  (WIDTH),
    .MODULO (64'd10)
`ifdef COUNTER_PRESCALE_EN
    ,
    .PRESCALE (PS)
`endif
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .EN         (EN),
    .CLR        (CLR),
    .LOAD       (LOAD),
    .load_value (load_value),
    .UP         (UP),
    .SAT        (SAT),
    .FLAG_CLR   (FLAG_CLR),
    .counter    (counter),
    .OV         (OV),
    .UF         (UF),
    .OV_STK     (OV_STK),
    .UF_STK     (UF_STK),
    .TC         (TC)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  // One count step: EN held for PS cycles (one cycle in the plain build).
  task automatic step_en();
    EN = 1'b1;
    repeat (PS) clk1();
    EN = 1'b0;
  endtask

  task automatic do_load(input logic [WIDTH-1:0] v);
    LOAD = 1'b1; load_value = v;
    clk1();
    LOAD = 1'b0;
  endtask

  initial begin
    Reset = 1'b1; EN = 0; CLR = 0; LOAD = 0; UP = 0; SAT = 0; FLAG_CLR = 0;
    load_value = '0;
    clk1(); clk1();
    check("rst_cnt", 32'(counter), 0);
    check("rst_ov",  32'(OV), 0);
    check("rst_uf",  32'(UF), 0);
    check("rst_ovs", 32'(OV_STK), 0);
    check("rst_ufs", 32'(UF_STK), 0);
    check("rst_tc_down", 32'(TC), 1);
    Reset = 1'b0;

    // Wrap up: 1..9, 0, 1, 2
    UP = 1'b1; SAT = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      step_en();
      check($sformatf("wrap_cnt%0d", i), 32'(counter), 32'(i % 10));
      check($sformatf("wrap_ov%0d", i), 32'(OV), (i == 10) ? 1 : 0);
      if (i == 9) check("wrap_tc9", 32'(TC), 1);
    end
    check("wrap_ovs", 32'(OV_STK), 1);

    // Saturate down from 2: 1, 0, 0, 0 with UF on steps 3 and 4
    do_load(8'd2);
    check("load2", 32'(counter), 2);
    UP = 1'b0; SAT = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step_en();
      check($sformatf("sat_cnt%0d", i), 32'(counter), (i == 1) ? 1 : 0);
      check($sformatf("sat_uf%0d", i), 32'(UF), (i >= 3) ? 1 : 0);
      if (i >= 2) check($sformatf("sat_tc%0d", i), 32'(TC), 1);
    end
    check("sat_ufs", 32'(UF_STK), 1);
    clk1();
    check("idle_uf", 32'(UF), 0);
    check("idle_cnt", 32'(counter), 0);

    // Load clamp and priority
    do_load(8'd200);
    check("clamp_cnt", 32'(counter), 9);
    check("clamp_ov", 32'(OV), 0);
    LOAD = 1'b1; EN = 1'b1; UP = 1'b1; load_value = 8'd3;
    clk1();
    LOAD = 1'b0; EN = 1'b0;
    check("load_en", 32'(counter), 3);
    CLR = 1'b1; LOAD = 1'b1; load_value = 8'd5;
    clk1();
    CLR = 1'b0; LOAD = 1'b0;
    check("clr_load_cnt", 32'(counter), 0);
    check("clr_ovs", 32'(OV_STK), 0);
    check("clr_ufs", 32'(UF_STK), 0);

    // Sticky race: FLAG_CLR with an OV event
    do_load(8'd9);
    UP = 1'b1; SAT = 1'b0; FLAG_CLR = 1'b1;
    step_en();
    check("race_cnt", 32'(counter), 0);
    check("race_ov", 32'(OV), 1);
    check("race_ovs", 32'(OV_STK), 1);
    clk1();
    FLAG_CLR = 1'b0;
    check("fclr_ovs", 32'(OV_STK), 0);
    check("fclr_ov", 32'(OV), 0);

    // Reset mid-count with a sticky flag set
    do_load(8'd9);
    step_en();
    check("pre_rst_ovs", 32'(OV_STK), 1);
    do_load(8'd7);
    check("pre_rst_cnt", 32'(counter), 7);
    Reset = 1'b1; EN = 1'b1;
    clk1();
    Reset = 1'b0; EN = 1'b0;
    check("rst_mid_cnt", 32'(counter), 0);
    check("rst_mid_ovs", 32'(OV_STK), 0);
    check("rst_mid_ov", 32'(OV), 0);
    step_en();
    check("resume_cnt", 32'(counter), 1);

    // Down wrap: 1 -> 0 -> 9 with UF
    UP = 1'b0; SAT = 1'b0;
    step_en();
    check("dn_cnt0", 32'(counter), 0);
    step_en();
    check("dn_wrap_cnt", 32'(counter), 9);
    check("dn_wrap_uf", 32'(UF), 1);
    check("dn_wrap_ufs", 32'(UF_STK), 1);
    check("dn_tc_down9", 32'(TC), 0);
    UP = 1'b1;
    #1;
    check("tc_up9_comb", 32'(TC), 1);

`ifdef COUNTER_PRESCALE_EN
    // Prescale window: 8 enabled cycles -> 2 steps; LOAD restarts the window
    CLR = 1'b1; clk1(); CLR = 1'b0;
    EN = 1'b1;
    repeat (8) clk1();
    check("ps_8cyc", 32'(counter), 2);
    repeat (2) clk1();
    check("ps_partial", 32'(counter), 2);
    LOAD = 1'b1; load_value = 8'd5;
    clk1();
    LOAD = 1'b0;
    check("ps_load", 32'(counter), 5);
    repeat (3) clk1();
    check("ps_3after_load", 32'(counter), 5);
    clk1();
    check("ps_4after_load", 32'(counter), 6);
    EN = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
